mem_port_ctrl: RTL and testbench
================================

# mem_port_ctrl

Request-sequencing front end that sits directly upstream of the single-port `Memory` block (DW=16, W=256, combinational read, write on clock edge, shared tristate data bus). It accepts read/write requests over a valid/ready handshake and buffers them in a small in-order FIFO. It drives `re`, `we`, `addr` and the tristate data bus with strict bus discipline, and returns read data over a second valid/ready handshake.

## Interface
Parameters:
- DW, 16, data word width; must match the memory.
- W, 256, memory depth in words.
- AW, $clog2(W), address width.
- DEPTH, 4, request FIFO entries; power of two, ≥2.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_L  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  FIFO can accept; equals !full.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  AW  request address.
- req_wdata  input  DW  write data; ignored for reads.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer takes read data.
- rsp_rdata  output  DW  read data.
- mem_re  output  1  memory read enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_data  inout  DW  tristate memory data bus.
- idle  output  1  FIFO empty and FSM in IDLE.

## Operation
- Request accepted on an edge where req_valid && req_ready. The {write, addr, wdata} tuple is pushed into the FIFO.
- req_ready = !full, independent of a same-cycle pop. A full FIFO never accepts, even while popping.
- Requests are executed strictly in order. Read-after-write to the same address returns the new data.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into the op register (addr, wdata, write). Go to WRITE if write, READ if read. Otherwise stay in IDLE.
  - WRITE: mem_we=1; mem_data driven with op wdata. The memory commits at the end-of-cycle edge. Next state IDLE.
  - READ: mem_re=1; mem_data is not driven. rsp_rdata register loads mem_data at the end-of-cycle edge. Next state RESP.
  - RESP: rsp_valid=1. Stay until rsp_ready=1, then go to IDLE at that edge.
- mem_re and mem_we are decoded combinationally from state and are never both 1.
- The controller drives mem_data only in WRITE; otherwise the bus is 'z.
- mem_addr = op register address; it is held constant through WRITE, READ and RESP.
- rsp_rdata is stable while rsp_valid=1 and holds its last value afterwards.
- Addresses are used verbatim with no wrap logic. 0xFF and 0x00 are distinct words.
- FIFO pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. A separate count register holds values 0..DEPTH.

## Timing
- Reset (reset_L=0, asynchronous) produces:
  - state IDLE;
  - FIFO empty, so req_ready=1;
  - op register 0, mem_addr=0;
  - mem_re=0, mem_we=0, mem_data='z;
  - rsp_valid=0, rsp_rdata=0;
  - idle=1.
- Memory contents are not reset.
- Reset mid-operation discards the in-flight op and all queued requests. mem_we/mem_re drop immediately.
- Request accepted at edge E0: popped at E1; WRITE/READ during the cycle after E1; write commits / read captured at E2.
- rsp_valid rises after E2, so minimum read latency is 2 edges.
- Throughput: one write per 2 cycles; one read per 3 cycles with rsp_ready held high.
- rsp_ready is ignored outside RESP.
- While in RESP, the FIFO keeps accepting requests until full.

## Structure
- Package mem_port_pkg holds:
  - enum state_t {IDLE, WRITE, READ, RESP};
  - struct mem_req_t {write, addr, wdata}, parameterised via package localparams AW=8, DW=16.
- Sub-module req_fifo provides the synchronous FIFO of mem_req_t:
  - DEPTH entries;
  - push/pop/full/empty;
  - asynchronous active-low reset.
- The top level holds the FSM, op register, rsp_rdata register and tristate assign. It is instantiated alongside `Memory` sharing mem_data.

## Test plan
- Reset scenario: assert reset_L=0 mid-simulation. Required: req_ready=1, rsp_valid=0, mem_re=mem_we=0, mem_data=z and idle=1, all immediately.
- Basic write/read: write 0x12←0xBEEF, then read 0x12. Required: mem_we high exactly 1 cycle with bus=0xBEEF; rsp_valid 2 edges after read acceptance with rsp_rdata=0xBEEF.
- Full FIFO: read 0x00 with rsp_ready=0, then 5 back-to-back writes. Required: 4 writes accepted, req_ready=0 on the 5th; after rsp_ready=1 the writes drain in order.
- Backpressure: hold rsp_ready=0 for 10 cycles after a read of 0x34 (holding 0x5A5A). Required: rsp_valid and rsp_rdata=0x5A5A stable for all 10 cycles; one response consumed on release.
- Reset mid-read: pull reset_L low during READ. Required: mem_re drops immediately, no rsp_valid ever asserted, FIFO empty after release.
- Boundary addresses: write 0xFF←0x1111 and 0x00←0x2222, then read both. Required: 0x1111 and 0x2222 returned in order; bus contention checker reports no cycle with mem_re=1 while the controller drives mem_data.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types for the memory port controller: FSM state encoding and the
// request tuple carried through the request FIFO.
package mem_port_pkg;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/req_fifo.sv
// In-order request FIFO of mem_req_t; pointers wrap modulo DEPTH and a
// separate count register distinguishes full from empty.
module req_fifo
    import mem_port_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset_L,
    input  logic     push,
    input  mem_req_t push_data,
    input  logic     pop,
    output mem_req_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    mem_req_t        slots [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    // full gates push even when a pop happens in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

    assign pop_data = slots[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Request sequencer in front of the single-port Memory: queues requests,
// drives re/we/addr and the shared data bus, and returns read data.
module mem_port_ctrl #(
    parameter int unsigned DW    = 16,
    parameter int unsigned W     = 256,
    parameter int unsigned AW    = $clog2(W),
    parameter int unsigned DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data,
    output logic          idle
);

    import mem_port_pkg::*;

    state_t   state;
    state_t   next_state;
    mem_req_t op;
    mem_req_t req_in;
    mem_req_t head;
    logic     full;
    logic     empty;
    logic     pop;

    assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata};

    req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_L   (reset_L),
        .push      (req_valid),
        .push_data (req_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign req_ready = !full;
    assign pop       = (state == IDLE) && !empty;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            op        <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= next_state;
            if (pop) op <= head;
            if (state == READ) rsp_rdata <= mem_data;
        end
    end

    always_comb begin
        next_state = state;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) next_state = head.write ? WRITE : READ;
            end
            WRITE: begin
                mem_we     = 1'b1;
                next_state = IDLE;
            end
            READ: begin
                mem_re     = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // the bus is released in every state except WRITE so the memory can drive reads
    assign mem_data = (state == WRITE) ? op.wdata : 'z;
    assign mem_addr = op.addr;
    assign idle     = empty && (state == IDLE);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural single-port memory on
// the shared bus and a bus-contention monitor.
module tb_mem_port_ctrl;

    logic        clock = 1'b0;
    logic        reset_L;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_addr;
    wire  [15:0] mem_data;
    logic        idle;

    logic [15:0] mem_array [256] = '{default: '0};
    logic        probe_en;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          contention_errs = 0;

    always #5 clock = ~clock;

    mem_port_ctrl #(
        .DW    (16),
        .W     (256),
        .DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .idle      (idle)
    );

    // Memory model: combinational read onto the bus, write on clock edge
    assign mem_data = mem_re ? mem_array[mem_addr] : 'z;
    always @(posedge clock) if (mem_we) mem_array[mem_addr] <= mem_data;

    // Known pattern used to show the controller has released the bus
    assign mem_data = probe_en ? 16'hA5C3 : 'z;

    always @(negedge clock) begin
        if (reset_L) begin
            if (mem_re && mem_we) contention_errs++;
            if (mem_re && (mem_data !== mem_array[mem_addr])) contention_errs++;
        end
    end

    task automatic send(input logic w, input logic [7:0] a, input logic [15:0] d);
        int unsigned n = 0;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL send_ready: got %b expected 1", req_ready);
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clock);
        while (!idle && n < 50) begin
            @(negedge clock);
            n++;
        end
        tests_run++;
        if (idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_idle: got %b expected 1", idle);
        end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        send(1'b1, 8'h12, 16'hBEEF);
        @(negedge clock);
        tests_run++;
        if (mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_pre_we: got %b expected 0", mem_we);
        end
        @(negedge clock);
        tests_run++;
        if (mem_we !== 1'b1 || mem_data !== 16'hBEEF || mem_addr !== 8'h12) begin
            tests_failed++;
            $display("FAIL wr_cycle: got we=%b data=%h addr=%h expected we=1 data=beef addr=12",
                     mem_we, mem_data, mem_addr);
        end
        @(negedge clock);
        tests_run++;
        if (mem_we !== 1'b0 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_post: got we=%b idle=%b expected we=0 idle=1", mem_we, idle);
        end
        send(1'b0, 8'h12, 16'h0000);
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 1'b0 || mem_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_e1: got rsp_valid=%b re=%b expected 0 0", rsp_valid, mem_re);
        end
        @(negedge clock);
        tests_run++;
        if (mem_re !== 1'b1 || mem_addr !== 8'h12 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_cycle: got re=%b addr=%h rsp_valid=%b expected 1 12 0",
                     mem_re, mem_addr, rsp_valid);
        end
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL rd_resp: got valid=%b data=%h expected 1 beef", rsp_valid, rsp_rdata);
        end
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_done: got valid=%b idle=%b expected 0 1", rsp_valid, idle);
        end
    endtask

    task automatic test_reset();
        send(1'b1, 8'h60, 16'h1234);
        send(1'b1, 8'h61, 16'h4321);
        @(negedge clock);
        tests_run++;
        if (mem_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_we: got %b expected 1", mem_we);
        end
        reset_L = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 ||
            idle !== 1'b1 || mem_addr !== 8'h00 || rsp_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_state: got ready=%b valid=%b re=%b we=%b idle=%b addr=%h rdata=%h expected 1 0 0 0 1 00 0000",
                     req_ready, rsp_valid, mem_re, mem_we, idle, mem_addr, rsp_rdata);
        end
        probe_en = 1'b1;
        #1;
        tests_run++;
        if (mem_data !== 16'hA5C3) begin
            tests_failed++;
            $display("FAIL rst_bus_z: got %h expected a5c3 (bus released)", mem_data);
        end
        probe_en = 1'b0;
        @(negedge clock);
        reset_L = 1'b1;
        repeat (6) @(negedge clock);
        tests_run++;
        if (mem_array[8'h60] !== 16'h0000 || mem_array[8'h61] !== 16'h0000 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_discard: got m60=%h m61=%h idle=%b expected 0000 0000 1",
                     mem_array[8'h60], mem_array[8'h61], idle);
        end
    endtask

    task automatic test_full();
        logic [4:0]  ready_seen;
        logic [7:0]  wr_addr [8];
        logic [15:0] wr_data [8];
        int unsigned n_wr = 0;
        rsp_ready = 1'b0;
        send(1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            ready_seen[i] = req_ready;
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 8'h40 + 8'(i);
            req_wdata = 16'hA000 + 16'(i);
        end
        @(negedge clock);
        req_valid = 1'b0;
        tests_run++;
        if (ready_seen !== 5'b01111) begin
            tests_failed++;
            $display("FAIL full_accept: got ready pattern %b expected 01111", ready_seen);
        end
        tests_run++;
        if (req_ready !== 1'b0 || idle !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL full_hold: got ready=%b idle=%b valid=%b rdata=%h expected 0 0 1 0000",
                     req_ready, idle, rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (mem_we && n_wr < 8) begin
                wr_addr[n_wr] = mem_addr;
                wr_data[n_wr] = mem_data;
                n_wr++;
            end
        end
        tests_run++;
        if (n_wr != 4) begin
            tests_failed++;
            $display("FAIL full_drain_count: got %0d writes expected 4", n_wr);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (wr_addr[k] !== 8'h40 + 8'(k) || wr_data[k] !== 16'hA000 + 16'(k)) begin
                tests_failed++;
                $display("FAIL full_drain_order[%0d]: got addr=%h data=%h expected %h %h",
                         k, wr_addr[k], wr_data[k], 8'h40 + 8'(k), 16'hA000 + 16'(k));
            end
        end
        tests_run++;
        if (mem_array[8'h44] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL full_reject: got m44=%h expected 0000", mem_array[8'h44]);
        end
    endtask

    task automatic test_backpressure();
        int unsigned n = 0;
        int unsigned extra = 0;
        rsp_ready = 1'b1;
        send(1'b1, 8'h34, 16'h5A5A);
        wait_idle();
        rsp_ready = 1'b0;
        send(1'b0, 8'h34, 16'h0000);
        @(negedge clock);
        while (!rsp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h5A5A) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1 5a5a", c, rsp_valid, rsp_rdata);
            end
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL bp_release: got valid=%b data=%h expected 0 5a5a", rsp_valid, rsp_rdata);
        end
        repeat (5) begin
            @(negedge clock);
            if (rsp_valid) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++;
            $display("FAIL bp_single: got %0d extra responses expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_read();
        int unsigned n = 0;
        int unsigned seen = 0;
        rsp_ready = 1'b1;
        send(1'b0, 8'h34, 16'h0000);
        send(1'b1, 8'h50, 16'h7777);
        @(negedge clock);
        while (!mem_re && n < 20) begin
            @(negedge clock);
            n++;
        end
        tests_run++;
        if (mem_re !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmr_reach_read: got re=%b expected 1", mem_re);
        end
        reset_L = 1'b0;
        #1;
        tests_run++;
        if (mem_re !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmr_drop: got re=%b valid=%b expected 0 0", mem_re, rsp_valid);
        end
        @(negedge clock);
        reset_L = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (rsp_valid || mem_we) seen++;
        end
        tests_run++;
        if (seen != 0 || idle !== 1'b1 || req_ready !== 1'b1 || mem_array[8'h50] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rmr_empty: got activity=%0d idle=%b ready=%b m50=%h expected 0 1 1 0000",
                     seen, idle, req_ready, mem_array[8'h50]);
        end
    endtask

    task automatic test_boundary();
        logic [15:0] rsp [4];
        int unsigned n_rsp = 0;
        rsp_ready = 1'b1;
        send(1'b1, 8'hFF, 16'h1111);
        send(1'b1, 8'h00, 16'h2222);
        send(1'b0, 8'hFF, 16'h0000);
        send(1'b0, 8'h00, 16'h0000);
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (rsp_valid && n_rsp < 4) begin
                rsp[n_rsp] = rsp_rdata;
                n_rsp++;
            end
        end
        tests_run++;
        if (n_rsp != 2 || rsp[0] !== 16'h1111 || rsp[1] !== 16'h2222) begin
            tests_failed++;
            $display("FAIL bnd_rsp: got n=%0d r0=%h r1=%h expected 2 1111 2222", n_rsp, rsp[0], rsp[1]);
        end
        tests_run++;
        if (mem_array[8'hFF] !== 16'h1111 || mem_array[8'h00] !== 16'h2222) begin
            tests_failed++;
            $display("FAIL bnd_mem: got mff=%h m00=%h expected 1111 2222", mem_array[8'hFF], mem_array[8'h00]);
        end
        tests_run++;
        if (contention_errs != 0) begin
            tests_failed++;
            $display("FAIL bus_contention: got %0d bad cycles expected 0", contention_errs);
        end
    endtask

    initial begin
        reset_L   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        probe_en  = 1'b0;
        repeat (2) @(negedge clock);
        reset_L = 1'b1;

        test_write_read();
        test_reset();
        test_full();
        test_backpressure();
        test_reset_mid_read();
        test_boundary();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
